// File: rtl/shooter_sprite_ctrl.sv
// Shooter sprite sequencer: fetches one ROM row per hblank into a line buffer,
// serialises it at shooter_x during active video, and moves the shooter per frame.
module shooter_sprite_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int Y_POS    = 440,
    parameter int X_INIT   = 312,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 624,
    parameter int STEP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        line_start,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [3:0]  rom_row_index,
    input  logic [15:0] rom_row_data,
    output logic [9:0]  shooter_x,
    output logic        line_valid,
    output logic        pixel_on
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam logic [9:0]  Y_LO    = 10'(Y_POS);
    localparam logic [9:0]  Y_HI    = 10'(Y_POS + 15);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  X_RST   = 10'(X_INIT);
    localparam logic [9:0]  X_LO    = 10'(X_MIN);
    localparam logic [9:0]  X_HI    = 10'(X_MAX);
    localparam logic [10:0] STEP_11 = 11'(STEP);
    localparam logic [10:0] LEFT_TH = 11'(X_MIN + STEP);
    localparam logic [10:0] X_HI_11 = 11'(X_MAX);

    logic [1:0]  state;
    logic [15:0] line_buf;
    logic [9:0]  nv;
    logic        in_rows;
    logic [9:0]  off;
    logic        hit;
    logic [10:0] x_11;

    always_comb begin
        nv      = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        in_rows = (nv >= Y_LO) && (nv <= Y_HI);
    end

    // Row fetch for the upcoming scanline; pulses arriving mid-fetch are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rom_row_index <= 4'd0;
            line_buf      <= 16'd0;
            line_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        if (in_rows) begin
                            rom_row_index <= nv[3:0] - Y_LO[3:0];
                            state         <= S_FETCH;
                        end else begin
                            line_valid <= 1'b0;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    line_buf   <= rom_row_data;
                    line_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        off = hpos - shooter_x;
        hit = line_valid && (hpos < H_ACT) && (hpos >= shooter_x)
              && (off[9:4] == 6'd0) && line_buf[4'd15 - off[3:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pixel_on <= 1'b0;
        else     pixel_on <= hit;
    end

    assign x_11 = {1'b0, shooter_x};

    // Widened to 11 bits so the step never wraps before the clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shooter_x <= X_RST;
        end else if (frame_tick) begin
            if (btn_left && !btn_right) begin
                shooter_x <= (x_11 < LEFT_TH) ? X_LO : 10'(x_11 - STEP_11);
            end else if (btn_right && !btn_left) begin
                shooter_x <= (x_11 + STEP_11 > X_HI_11) ? X_HI
                                                        : 10'(x_11 + STEP_11);
            end
        end
    end

endmodule

// File: tb/tb_shooter_sprite_ctrl.sv
// Testbench for shooter_sprite_ctrl: fetch timing, rendering via a pixel
// scoreboard, table-driven movement, and reset/simultaneity corners.
module tb_shooter_sprite_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        line_start;
    logic        frame_tick;
    logic        btn_left;
    logic        btn_right;
    logic [3:0]  rom_row_index;
    logic [15:0] rom_row_data;
    logic [9:0]  shooter_x;
    logic        line_valid;
    logic        pixel_on;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic l;
        logic r;
        logic tk;
        int   n;
        int   exp;
    } mv_t;

    mv_t  mv[11];
    logic exp_q[$];
    int   h_q[$];

    always #5 clk = ~clk;

    shooter_sprite_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hpos         (hpos),
        .vpos         (vpos),
        .line_start   (line_start),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .rom_row_index(rom_row_index),
        .rom_row_data (rom_row_data),
        .shooter_x    (shooter_x),
        .line_valid   (line_valid),
        .pixel_on     (pixel_on)
    );

    function automatic logic [15:0] rom_f(input logic [3:0] i);
        case (i)
            4'd0:    rom_f = 16'h0180;
            4'd7:    rom_f = 16'hFFFF;
            4'd15:   rom_f = 16'h8001;
            default: rom_f = {i, ~i, i, ~i};
        endcase
    endfunction

    assign rom_row_data = rom_f(rom_row_index);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int v);
        vpos       = 10'(v);
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic px(input int h, input logic e);
        logic got_e;
        int   got_h;
        hpos = 10'(h);
        exp_q.push_back(e);
        h_q.push_back(h);
        cyc();
        got_e = exp_q.pop_front();
        got_h = h_q.pop_front();
        chk($sformatf("pixel h=%0d", got_h), int'(pixel_on), int'(got_e));
    endtask

    initial begin
        mv[0]  = '{1'b1, 1'b0, 1'b1, 155, 2};
        mv[1]  = '{1'b1, 1'b0, 1'b1, 1,   0};
        mv[2]  = '{1'b1, 1'b0, 1'b1, 44,  0};
        mv[3]  = '{1'b1, 1'b0, 1'b0, 20,  0};
        mv[4]  = '{1'b0, 1'b1, 1'b1, 311, 622};
        mv[5]  = '{1'b0, 1'b1, 1'b1, 1,   624};
        mv[6]  = '{1'b0, 1'b1, 1'b1, 10,  624};
        mv[7]  = '{1'b1, 1'b1, 1'b1, 5,   624};
        mv[8]  = '{1'b0, 1'b0, 1'b1, 5,   624};
        mv[9]  = '{1'b1, 1'b0, 1'b1, 1,   622};
        mv[10] = '{1'b0, 1'b1, 1'b1, 1,   624};

        rst        = 1'b1;
        hpos       = 10'd0;
        vpos       = 10'd0;
        line_start = 1'b0;
        frame_tick = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        cyc();
        cyc();
        chk("reset x", int'(shooter_x), 312);
        chk("reset valid", int'(line_valid), 0);
        chk("reset pixel", int'(pixel_on), 0);
        chk("reset row", int'(rom_row_index), 0);
        rst = 1'b0;

        // Fetch of row 0 for line 440
        hpos = 10'd640;
        fetch(439);
        chk("f0 row", int'(rom_row_index), 0);
        chk("f0 valid c1", int'(line_valid), 0);
        cyc();
        chk("f0 valid c2", int'(line_valid), 0);
        cyc();
        chk("f0 valid c3", int'(line_valid), 1);

        for (int h = 0; h < 800; h++) px(h, (h == 319) || (h == 320));

        // line_start during FETCH and LOAD must be dropped
        hpos = 10'd640;
        fetch(439);
        vpos       = 10'd445;
        line_start = 1'b1;
        cyc();
        cyc();
        line_start = 1'b0;
        chk("ignore row", int'(rom_row_index), 0);
        cyc();
        cyc();
        chk("ignore row later", int'(rom_row_index), 0);

        // Last sprite row, then leaving the sprite band
        fetch(454);
        chk("f15 row", int'(rom_row_index), 15);
        cyc();
        cyc();
        chk("f15 valid", int'(line_valid), 1);
        for (int h = 305; h < 336; h++) px(h, (h == 312) || (h == 327));
        hpos = 10'd640;
        fetch(455);
        chk("past band valid", int'(line_valid), 0);
        for (int h = 305; h < 336; h++) px(h, 1'b0);
        hpos = 10'd640;
        fetch(456);
        chk("456 valid", int'(line_valid), 0);
        fetch(524);
        chk("wrap row", int'(rom_row_index), 15);
        cyc();
        cyc();
        chk("wrap valid", int'(line_valid), 0);

        for (int i = 0; i < 11; i++) begin
            btn_left   = mv[i].l;
            btn_right  = mv[i].r;
            frame_tick = mv[i].tk;
            repeat (mv[i].n) cyc();
            frame_tick = 1'b0;
            btn_left   = 1'b0;
            btn_right  = 1'b0;
            chk($sformatf("move %0d", i), int'(shooter_x), mv[i].exp);
        end

        // Row 7 at the right edge
        hpos = 10'd640;
        fetch(446);
        chk("f7 row", int'(rom_row_index), 7);
        cyc();
        cyc();
        chk("f7 valid", int'(line_valid), 1);
        for (int h = 600; h < 800; h++) px(h, (h >= 624) && (h <= 639));

        // frame_tick and line_start in the same cycle
        hpos       = 10'd640;
        vpos       = 10'd439;
        line_start = 1'b1;
        frame_tick = 1'b1;
        btn_left   = 1'b1;
        cyc();
        line_start = 1'b0;
        frame_tick = 1'b0;
        btn_left   = 1'b0;
        chk("sim x", int'(shooter_x), 622);
        chk("sim row", int'(rom_row_index), 0);
        cyc();
        cyc();
        chk("sim valid", int'(line_valid), 1);
        for (int h = 600; h < 660; h++) px(h, (h == 629) || (h == 630));

        // Asynchronous reset in the middle of a fetch
        px(629, 1'b1);
        hpos = 10'd640;
        fetch(445);
        chk("pre-rst row", int'(rom_row_index), 6);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst x", int'(shooter_x), 312);
        chk("mid rst valid", int'(line_valid), 0);
        chk("mid rst pixel", int'(pixel_on), 0);
        chk("mid rst row", int'(rom_row_index), 0);
        cyc();
        rst = 1'b0;
        fetch(439);
        cyc();
        cyc();
        chk("post rst valid", int'(line_valid), 1);
        for (int h = 315; h < 326; h++) px(h, (h == 319) || (h == 320));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
